// File: rtl/front_part_strip_allocator_pkg.sv
// rtl/front_part_strip_allocator_pkg.sv - shared state encoding, defaults and field widths
package front_part_pkg;
  localparam int DEF_NUM_STRIPS     = 14;
  localparam int DEF_STRIP_CAPACITY = 128;
  localparam int STRIP_ID_W         = 4;
  localparam int OCC_W              = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_EMIT,
    ST_REJECT
  } state_e;
endpackage

// File: rtl/front_part_strip_allocator_if.sv
// rtl/front_part_strip_allocator_if.sv - request handshake and strip-write beat bundle
interface front_part_strip_allocator_if;
  import front_part_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [OCC_W-1:0]      req_width;
  logic                  clear_all;
  logic                  write_valid;
  logic                  strike_flag_write;
  logic [STRIP_ID_W-1:0] strip_ID_write;
  logic [OCC_W-1:0]      old_occupied_width_write;
  logic [OCC_W-1:0]      new_occupied_width_write;
  logic                  req_reject;

  modport master (
    output req_valid, req_width, clear_all,
    input  req_ready, write_valid, strike_flag_write, strip_ID_write,
    input  old_occupied_width_write, new_occupied_width_write, req_reject
  );

  modport slave (
    input  req_valid, req_width, clear_all,
    output req_ready, write_valid, strike_flag_write, strip_ID_write,
    output old_occupied_width_write, new_occupied_width_write, req_reject
  );
endinterface

// File: rtl/front_part_strip_allocator_strip_fit_compare.sv
// rtl/front_part_strip_allocator_strip_fit_compare.sv - per-strip fit test; FRONT_PART_BEST_FIT_EN selects best fit
module strip_fit_compare
  import front_part_pkg::*;
#(
  parameter int STRIP_CAPACITY = DEF_STRIP_CAPACITY
) (
  input  logic [OCC_W-1:0] i_occ,
  input  logic [OCC_W-1:0] i_width,
  input  logic [OCC_W-1:0] i_best_rem,
  input  logic             i_candidate_valid,
  output logic             o_fit,
  output logic             o_replace
);
  logic [OCC_W:0] w_sum;

  assign w_sum = {1'b0, i_occ} + {1'b0, i_width};
  assign o_fit = (w_sum <= (OCC_W+1)'(STRIP_CAPACITY));

`ifdef FRONT_PART_BEST_FIT_EN
  logic [OCC_W-1:0] w_rem;
  assign w_rem = OCC_W'(STRIP_CAPACITY) - w_sum[OCC_W-1:0];
  // strict less-than keeps the lowest strip ID on ties
  assign o_replace = o_fit && (!i_candidate_valid || (w_rem < i_best_rem));
`else
  logic w_unused;
  assign w_unused  = ^i_best_rem;
  assign o_replace = o_fit && !i_candidate_valid;
`endif
endmodule

// File: rtl/front_part_strip_allocator.sv
// rtl/front_part_strip_allocator.sv - strip placement FSM with fixed-latency scan; FRONT_PART_BEST_FIT_EN selects best fit
module front_part_strip_allocator
  import front_part_pkg::*;
#(
  parameter int NUM_STRIPS     = DEF_NUM_STRIPS,
  parameter int STRIP_CAPACITY = DEF_STRIP_CAPACITY
) (
  input logic                        clk,
  input logic                        rst,
  front_part_strip_allocator_if.slave bus
);
  state_e r_state, w_next;

  logic [OCC_W-1:0]      r_occ [NUM_STRIPS];
  logic [OCC_W-1:0]      r_width;
  logic [STRIP_ID_W-1:0] r_idx;
  logic                  r_cand_valid;
  logic [STRIP_ID_W-1:0] r_cand_id;
  logic [OCC_W-1:0]      r_cand_old;
  logic [OCC_W-1:0]      r_best_rem;

  logic                  r_write_valid, r_strike, r_req_reject;
  logic [STRIP_ID_W-1:0] r_strip_id;
  logic [OCC_W-1:0]      r_old, r_new;

  logic                  w_fit, w_replace, w_take, w_last, w_bad, w_handshake;
  logic                  w_final_valid;
  logic [STRIP_ID_W-1:0] w_final_id;
  logic [OCC_W-1:0]      w_occ_cur, w_rem, w_final_old, w_final_new;

  assign bus.req_ready  = (r_state == ST_IDLE) && !rst && !bus.clear_all;
  assign w_handshake    = bus.req_valid && bus.req_ready;
  assign w_bad          = (bus.req_width == '0) || (bus.req_width > OCC_W'(STRIP_CAPACITY));

  assign w_occ_cur      = r_occ[r_idx];
  assign w_rem          = OCC_W'(STRIP_CAPACITY) - (w_occ_cur + r_width);
  assign w_last         = (r_idx == STRIP_ID_W'(NUM_STRIPS - 1));
  assign w_take         = w_fit && w_replace;
  // the last strip's verdict is folded in here so outputs load on the final scan edge
  assign w_final_valid  = r_cand_valid || w_take;
  assign w_final_id     = w_take ? r_idx : r_cand_id;
  assign w_final_old    = w_take ? w_occ_cur : r_cand_old;
  assign w_final_new    = w_final_old + r_width;

  strip_fit_compare #(.STRIP_CAPACITY(STRIP_CAPACITY)) u_fit (
    .i_occ             (w_occ_cur),
    .i_width           (r_width),
    .i_best_rem        (r_best_rem),
    .i_candidate_valid (r_cand_valid),
    .o_fit             (w_fit),
    .o_replace         (w_replace)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_handshake) w_next = w_bad ? ST_REJECT : ST_SCAN;
      ST_SCAN:   if (w_last)      w_next = w_final_valid ? ST_EMIT : ST_REJECT;
      ST_EMIT:   w_next = ST_IDLE;
      ST_REJECT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STRIPS; i++) r_occ[i] <= '0;
      r_width       <= '0;
      r_idx         <= '0;
      r_cand_valid  <= 1'b0;
      r_cand_id     <= '0;
      r_cand_old    <= '0;
      r_best_rem    <= '0;
      r_write_valid <= 1'b0;
      r_req_reject  <= 1'b0;
      r_strike      <= 1'b0;
      r_strip_id    <= '0;
      r_old         <= '0;
      r_new         <= '0;
    end else begin
      r_write_valid <= 1'b0;
      r_req_reject  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.clear_all) begin
            for (int i = 0; i < NUM_STRIPS; i++) r_occ[i] <= '0;
          end else if (w_handshake) begin
            r_width      <= bus.req_width;
            r_idx        <= '0;
            r_cand_valid <= 1'b0;
            r_req_reject <= w_bad;
          end
        end
        ST_SCAN: begin
          if (w_take) begin
            r_cand_valid <= 1'b1;
            r_cand_id    <= r_idx;
            r_cand_old   <= w_occ_cur;
            r_best_rem   <= w_rem;
          end
          if (!w_last) begin
            r_idx <= r_idx + 1'b1;
          end else if (w_final_valid) begin
            r_write_valid       <= 1'b1;
            r_strip_id          <= w_final_id;
            r_old               <= w_final_old;
            r_new               <= w_final_new;
            r_strike            <= (w_final_new == OCC_W'(STRIP_CAPACITY));
            r_occ[w_final_id]   <= w_final_new;
          end else begin
            r_req_reject <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.write_valid              = r_write_valid;
  assign bus.req_reject               = r_req_reject;
  assign bus.strike_flag_write        = r_strike;
  assign bus.strip_ID_write           = r_strip_id;
  assign bus.old_occupied_width_write = r_old;
  assign bus.new_occupied_width_write = r_new;
endmodule

// File: tb/tb_front_part_strip_allocator.sv
// tb/tb_front_part_strip_allocator.sv - directed self-checking bench for front_part_strip_allocator
module tb_front_part_strip_allocator;
  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  front_part_strip_allocator_if bus ();

  front_part_strip_allocator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wv"},   bus.write_valid, 0);
    chk({tag, "_rej"},  bus.req_reject, 0);
    chk({tag, "_id"},   bus.strip_ID_write, 0);
    chk({tag, "_old"},  bus.old_occupied_width_write, 0);
    chk({tag, "_new"},  bus.new_occupied_width_write, 0);
    chk({tag, "_stk"},  bus.strike_flag_write, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // handshake at edge T; result expected in cycle T+15, ready again at T+16
  task automatic place(input string tag, input logic [7:0] w, input bit exp_rej,
                       input int exp_id, input int exp_old, input int exp_new, input bit exp_stk);
    int stray;
    stray = 0;
    @(negedge clk);
    chk({tag, "_rdy0"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_width = w;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      #1;
      if (bus.write_valid || bus.req_reject || bus.req_ready) stray++;
    end
    chk({tag, "_early"}, stray, 0);
    @(posedge clk);
    #1;
    chk({tag, "_wv"},  bus.write_valid, exp_rej ? 0 : 1);
    chk({tag, "_rej"}, bus.req_reject, exp_rej ? 1 : 0);
    if (!exp_rej) begin
      chk({tag, "_id"},  bus.strip_ID_write, exp_id);
      chk({tag, "_old"}, bus.old_occupied_width_write, exp_old);
      chk({tag, "_new"}, bus.new_occupied_width_write, exp_new);
      chk({tag, "_stk"}, bus.strike_flag_write, exp_stk);
    end
    @(posedge clk);
    #1;
    chk({tag, "_after"}, {bus.req_ready, bus.write_valid, bus.req_reject}, 3'b100);
  endtask

  task automatic bad_width(input string tag, input logic [7:0] w);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_width = w;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk({tag, "_rej"}, {bus.req_reject, bus.write_valid}, 2'b10);
    @(posedge clk);
    #1;
    chk({tag, "_after"}, {bus.req_ready, bus.req_reject, bus.write_valid}, 3'b100);
  endtask

  initial begin
    int stray;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_width = '0;
    bus.clear_all = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", bus.req_ready, 0);
    chk_all_zero("rst");
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", bus.req_ready, 1);

    place("first",  8'd50,  0, 0, 0,   50,  0);
    place("fill",   8'd78,  0, 0, 50,  128, 1);
    place("next",   8'd100, 0, 1, 0,   100, 0);
    bad_width("w0",   8'd0);
    bad_width("w129", 8'd129);
    place("unchg",  8'd28,  0, 1, 100, 128, 1);

    // clear_all wins over a simultaneous request
    @(negedge clk);
    bus.clear_all = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_width = 8'd5;
    #1;
    chk("clr_rdy", bus.req_ready, 0);
    @(posedge clk);
    #1;
    bus.clear_all = 1'b0;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("clr_quiet", {bus.req_ready, bus.write_valid, bus.req_reject}, 3'b100);
    place("clr_s0", 8'd20, 0, 0, 0, 20, 0);
    place("clr_s1", 8'd120, 0, 1, 0, 120, 0);

    // reset during cycle T+7 of a scan
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_width = 8'd30;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    chk("mid_rdy", bus.req_ready, 0);
    @(posedge clk);
    #1;
    chk_all_zero("mid");
    rst   = 1'b0;
    stray = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (bus.write_valid || bus.req_reject) stray++;
    end
    chk("mid_nopulse", stray, 0);
    place("mid_next", 8'd20, 0, 0, 0, 20, 0);

    do_reset();
    place("fm_a", 8'd10,  0, 0, 0, 10,  0);
    place("fm_b", 8'd120, 0, 1, 0, 120, 0);
`ifdef FRONT_PART_BEST_FIT_EN
    place("fm_c", 8'd8, 0, 1, 120, 128, 1);
`else
    place("fm_c", 8'd8, 0, 0, 10, 18, 0);
`endif

    do_reset();
    for (int i = 0; i < 14; i++) place($sformatf("full%0d", i), 8'd128, 0, i, 0, 128, 1);
    place("full_rej", 8'd1, 1, 0, 0, 0, 0);
    chk("hold_id",  bus.strip_ID_write, 13);
    chk("hold_new", bus.new_occupied_width_write, 128);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
